// File: rtl/am_rx_sequencer.sv
// am_rx_sequencer: sequences one AM demodulation pass over the ROM/multiply/filter chain with valid/ready output.
module am_rx_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic              filt_clr,
  input  logic [DATA_W-1:0] ynC_in,
  input  logic [DATA_W-1:0] ynS_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] outC,
  output logic [DATA_W-1:0] outS,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, rem_q, rem_d;
  logic [LAT-1:0] tag_q, tag_d;
  logic ov_q, ov_d, clr_q, done_q, busy_q, cap;
  logic [DATA_W-1:0] oc_q, oc_d, os_q, os_d;
  always_comb begin
    en = ((state_q == RUN) || (state_q == DRAIN && tag_q != '0)) && (!ov_q || out_ready);
    cap = en && tag_q[LAT-1];
    tag_d = en ? LAT'({tag_q, state_q == RUN}) : tag_q;
    ov_d = cap || (ov_q && !out_ready);
    oc_d = cap ? ynC_in : oc_q;
    os_d = cap ? ynS_in : os_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    state_d = state_q;
    case (state_q)
      IDLE: if (start) begin
        cnt_d = start_addr;
        rem_d = length;
        state_d = (length == '0) ? DONE : CLEAR;
      end
      CLEAR: state_d = RUN;
      RUN: if (en) begin
        rem_d = rem_q - ADDR_W'(1);
        // The last issue leaves the counter alone so addr holds through DRAIN
        if (rem_q != ADDR_W'(1)) cnt_d = cnt_q + ADDR_W'(1);
        else state_d = DRAIN;
      end
      DRAIN: state_d = (tag_d == '0 && !ov_d) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      tag_q <= '0;
      ov_q <= 1'b0;
      oc_q <= '0;
      os_q <= '0;
      clr_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      tag_q <= tag_d;
      ov_q <= ov_d;
      oc_q <= oc_d;
      os_q <= os_d;
      clr_q <= state_d == CLEAR;
      done_q <= state_d == DONE;
      busy_q <= state_d != IDLE;
    end
  end
  assign addr = cnt_q;
  assign filt_clr = clr_q;
  assign out_valid = ov_q;
  assign outC = oc_q;
  assign outS = os_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_am_rx_sequencer.sv
// tb_am_rx_sequencer: table-driven cycle checks plus wrap, zero-length and abort sequences.
module tb_am_rx_sequencer;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int L = 2;
  logic clk, rst, start, en, filt_clr, out_valid, out_ready, busy, done;
  logic [AW-1:0] start_addr, length, addr;
  logic [DW-1:0] ynC_in, ynS_in, outC, outS;
  int passed = 0, total = 0, cyc = 0;
  int beats, done_cyc, first_en, n_en, clr_seen;
  logic [AW-1:0] issued[8];
  typedef struct {
    logic st, rdy, clr, en;
    logic [AW-1:0] addr;
    logic ov;
    logic [DW-1:0] oc;
    logic dn, bz;
  } vec_t;
  vec_t tbl[25];

  am_rx_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .addr(addr), .en(en), .filt_clr(filt_clr), .ynC_in(ynC_in), .ynS_in(ynS_in),
    .out_valid(out_valid), .out_ready(out_ready), .outC(outC), .outS(outS),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
  endtask

  task automatic set_in(input logic s, input logic r);
    start = s;
    out_ready = r;
    ynC_in = 64'h1000 + 64'(cyc);
    ynS_in = 64'h2000 + 64'(cyc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_clr"}, 64'(filt_clr), 0);
    chk({tag, "_en"}, 64'(en), 0);
    chk({tag, "_addr"}, 64'(addr), 0);
    chk({tag, "_ov"}, 64'(out_valid), 0);
    chk({tag, "_outC"}, outC, 0);
    chk({tag, "_outS"}, outS, 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
  endtask

  function automatic vec_t v(input logic st, rdy, clr, e, input logic [AW-1:0] a,
                             input logic ov, input logic [DW-1:0] oc, input logic dn, bz);
    v = '{st, rdy, clr, e, a, ov, oc, dn, bz};
  endfunction

  // Runs a pass with out_ready held high; stops on done, on the cycle budget, or at abort_at (asserting rst)
  task automatic run_pass(input logic [AW-1:0] sa, input logic [AW-1:0] ln, input int abort_at);
    beats = 0; done_cyc = -1; first_en = -1; n_en = 0; clr_seen = 0;
    start_addr = sa;
    length = ln;
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      set_in(cyc == 0, 1'b1);
      @(negedge clk);
      if (cyc == abort_at) begin
        #1 rst = 1'b1;
        #1 return;
      end
      if (filt_clr) clr_seen++;
      if (en) begin
        if (first_en < 0) first_en = cyc;
        if (n_en < 8) issued[n_en] = addr;
        n_en++;
      end
      if (out_valid && out_ready) begin
        chk("beat_outC", outC, 64'h1000 + 64'(L + 2 + beats));
        chk("beat_outS", outS, 64'h2000 + 64'(L + 2 + beats));
        beats++;
      end
      if (done) done_cyc = cyc;
      @(posedge clk);
      #1 cyc++;
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
  endtask

  initial begin
    clk = 0; rst = 0; start = 0; out_ready = 1; start_addr = '0; length = 4;
    ynC_in = '0; ynS_in = '0;
    // Nominal pass, start_addr=0, length=4
    tbl[0]  = v(1, 1, 0, 0, 0, 0, 64'h0,    0, 0);
    tbl[1]  = v(0, 1, 1, 0, 0, 0, 64'h0,    0, 1);
    tbl[2]  = v(0, 1, 0, 1, 0, 0, 64'h0,    0, 1);
    tbl[3]  = v(0, 1, 0, 1, 1, 0, 64'h0,    0, 1);
    tbl[4]  = v(0, 1, 0, 1, 2, 0, 64'h0,    0, 1);
    tbl[5]  = v(0, 1, 0, 1, 3, 1, 64'h1004, 0, 1);
    tbl[6]  = v(0, 1, 0, 1, 3, 1, 64'h1005, 0, 1);
    tbl[7]  = v(0, 1, 0, 1, 3, 1, 64'h1006, 0, 1);
    tbl[8]  = v(0, 1, 0, 0, 3, 1, 64'h1007, 0, 1);
    tbl[9]  = v(0, 1, 0, 0, 3, 0, 64'h1007, 1, 1);
    tbl[10] = v(0, 1, 0, 0, 3, 0, 64'h1007, 0, 0);
    // Same pass with out_ready low in cycles 6-8
    tbl[11] = v(1, 1, 0, 0, 3, 0, 64'h1007, 0, 0);
    tbl[12] = v(0, 1, 1, 0, 0, 0, 64'h1007, 0, 1);
    tbl[13] = v(0, 1, 0, 1, 0, 0, 64'h1007, 0, 1);
    tbl[14] = v(0, 1, 0, 1, 1, 0, 64'h1007, 0, 1);
    tbl[15] = v(0, 1, 0, 1, 2, 0, 64'h1007, 0, 1);
    tbl[16] = v(0, 1, 0, 1, 3, 1, 64'h1004, 0, 1);
    tbl[17] = v(0, 0, 0, 0, 3, 1, 64'h1005, 0, 1);
    tbl[18] = v(0, 0, 0, 0, 3, 1, 64'h1005, 0, 1);
    tbl[19] = v(0, 0, 0, 0, 3, 1, 64'h1005, 0, 1);
    tbl[20] = v(0, 1, 0, 1, 3, 1, 64'h1005, 0, 1);
    tbl[21] = v(0, 1, 0, 1, 3, 1, 64'h1009, 0, 1);
    tbl[22] = v(0, 1, 0, 0, 3, 1, 64'h100a, 0, 1);
    tbl[23] = v(0, 1, 0, 0, 3, 0, 64'h100a, 1, 1);
    tbl[24] = v(0, 1, 0, 0, 3, 0, 64'h100a, 0, 0);
    #3 rst = 1'b1;
    #1 check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (tbl[i].st) cyc = 0;
      set_in(tbl[i].st, tbl[i].rdy);
      @(negedge clk);
      chk("tbl_clr", 64'(filt_clr), 64'(tbl[i].clr));
      chk("tbl_en", 64'(en), 64'(tbl[i].en));
      chk("tbl_addr", 64'(addr), 64'(tbl[i].addr));
      chk("tbl_ov", 64'(out_valid), 64'(tbl[i].ov));
      chk("tbl_outC", outC, tbl[i].oc);
      chk("tbl_outS", outS, (tbl[i].oc == 0) ? 64'h0 : tbl[i].oc + 64'h1000);
      chk("tbl_done", 64'(done), 64'(tbl[i].dn));
      chk("tbl_busy", 64'(busy), 64'(tbl[i].bz));
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    run_pass(10'd1022, 10'd3, -1);
    chk("wrap_a0", 64'(issued[0]), 1022);
    chk("wrap_a1", 64'(issued[1]), 1023);
    chk("wrap_a2", 64'(issued[2]), 0);
    chk("wrap_beats", 64'(beats), 3);
    chk("wrap_en_cycles", 64'(n_en), 3 + L);
    chk("wrap_done_cyc", 64'(done_cyc), 3 + L + 3);
    run_pass(10'd5, 10'd0, -1);
    chk("len0_done_cyc", 64'(done_cyc), 1);
    chk("len0_clr", 64'(clr_seen), 0);
    chk("len0_en", 64'(n_en), 0);
    chk("len0_beats", 64'(beats), 0);
    run_pass(10'd0, 10'd8, 5);
    chk("abort_no_done", 64'(done_cyc), 64'hffff_ffff_ffff_ffff);
    check_zero("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    run_pass(10'd0, 10'd8, -1);
    chk("restart_clr", 64'(clr_seen), 1);
    chk("restart_first_en", 64'(first_en), 2);
    chk("restart_beats", 64'(beats), 8);
    chk("restart_done_cyc", 64'(done_cyc), 8 + L + 3);
    chk("restart_a7", 64'(issued[7]), 7);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
